rc4_stream_host: RTL and testbench
==================================

# rc4_stream_host

Host-side counterpart of the RC4 cipher core. It owns the key and message buffers and drives the core's key, plaintext and ciphertext input streams. It captures the core's cipher and plain outputs, loops the captured ciphertext back for decryption, and compares the recovered plaintext against the original. It sits between the CPU/load interface and the RC4 core and provides a self-checking encrypt→decrypt round trip.

## Interface
- KEY_LEN, 32: key bytes sent after the preamble byte.
- MSG_LEN, 64: message bytes per round trip.
- TIMEOUT, 1024: maximum cycles allowed in any wait state before a timeout is declared.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a round trip from IDLE.
- load_en  in  1  buffer write strobe.
- load_sel  in  1  0 = key buffer, 1 = plaintext buffer.
- load_addr  in  6  buffer index (key uses bits [4:0]).
- load_data  in  8  byte to write.
- key_valid  out  1  key stream valid.
- key_in  out  8  key stream byte.
- plain_read  in  1  core requests plaintext.
- plain_in_valid  out  1  plaintext byte valid.
- plain_in  out  8  plaintext byte.
- cipher_write  in  1  core ciphertext strobe.
- cipher_out  in  8  ciphertext byte from core.
- cipher_read  in  1  core requests ciphertext.
- cipher_in_valid  out  1  ciphertext byte valid.
- cipher_in  out  8  ciphertext byte.
- plain_write  in  1  core recovered-plaintext strobe.
- plain_out  in  8  recovered byte from core.
- busy  out  1  high from start until finished.
- finished  out  1  sticky until next start.
- pass  out  1  valid when finished.
- timeout  out  1  sticky timeout flag.
- err_count  out  8  mismatch/overflow count, saturating at 255.

## Operation
- States: IDLE, KEY, WAIT_PR, PLAIN, WAIT_CR, CIPHER, FIN.
- IDLE: load_en writes the selected buffer. Loads in any other state are ignored. `start` moves to KEY, clears err_count, timeout, finished, pass and all pointers, and sets busy.
- KEY: key_valid=1 for exactly KEY_LEN+1 consecutive cycles.
  - Cycle 0: key_in=8'h00 (preamble, discarded by the core).
  - Cycle k (k=1..KEY_LEN): key_in=key_buf[k-1].
  - Then key_valid=0 and the block moves to WAIT_PR.
- WAIT_PR: plain_read sampled high moves to PLAIN.
- PLAIN (tx):
  - Each cycle plain_read is high and tx_ptr<MSG_LEN, the next cycle drives plain_in_valid=1, plain_in=plain_buf[tx_ptr], and tx_ptr increments.
  - If plain_read is low, plain_in_valid=0 and tx_ptr holds.
  - After MSG_LEN bytes, plain_in_valid stays 0.
- PLAIN (rx):
  - Each cycle cipher_write is high with rx_ptr<MSG_LEN: cipher_buf[rx_ptr]=cipher_out, rx_ptr++.
  - cipher_write with rx_ptr==MSG_LEN is an overflow: byte dropped, err_count+1.
  - tx_ptr==MSG_LEN and rx_ptr==MSG_LEN moves to WAIT_CR; both pointers clear.
- WAIT_CR: cipher_read sampled high moves to CIPHER.
- CIPHER: same handshake as PLAIN.
  - Drives cipher_in_valid/cipher_in from cipher_buf.
  - Each plain_write compares plain_out with plain_buf[rx_ptr]; a mismatch adds 1 to err_count. Overflow is handled as in PLAIN.
  - Both pointers at MSG_LEN moves to FIN.
- FIN: busy=0, finished=1, pass=(err_count==0 && !timeout). Next start restarts.
- Watchdog:
  - A cycle counter clears on every state change and on any handshake activity (plain_read, cipher_read, cipher_write, plain_write high).
  - Counter reaching TIMEOUT in WAIT_PR, PLAIN, WAIT_CR or CIPHER sets timeout and forces FIN with pass=0.
- Arithmetic: pointers are 7 bits wide, compared against MSG_LEN. err_count saturates at 8'hFF.
- start while busy is ignored.
- tx and rx events in the same cycle are both processed.

## Timing
- Reset values: key_valid, key_in, plain_in_valid, plain_in, cipher_in_valid, cipher_in, busy, finished, pass, timeout, err_count all 0; state IDLE. Buffers are not reset.
- Reset mid-operation aborts immediately to IDLE with the reset values above.
- start at cycle T: key_valid high for cycles T+1..T+1+KEY_LEN.
- plain_read high at cycle N: plain_in_valid high at cycle N+1 (one-cycle request-to-data latency). The same applies to cipher_read → cipher_in_valid.
- Outputs are registered. The last rx byte at cycle M gives a state change at M+1; finished is high at the cycle after FIN entry.

## Test plan
- Reset mid-KEY (cycle 10 of 33) → all outputs 0 next edge, state IDLE; a new start replays the preamble 8'h00.
- Load key bytes 0x00..0x1F and message 0x41..0x80, start, with a correct RC4 core model → key_valid high 33 cycles, first byte 8'h00; 64 cipher bytes captured; finished=1, pass=1, err_count=0.
- Same load, but the model corrupts recovered byte 5 (XOR 0x01) → err_count=1, pass=0.
- Model drops plain_read for 3 cycles mid-PLAIN → plain_in_valid low those cycles, no byte skipped or repeated, pass=1.
- Model issues 65 cipher_write pulses → err_count=1, pass=0, the 65th byte is not stored.
- Model never asserts cipher_read, with TIMEOUT=16 → timeout=1 after 16 idle cycles in WAIT_CR; finished=1, pass=0.

Source files
------------

// File: rtl/rc4_stream_host.sv
// rc4_stream_host: owns key/message buffers, streams them into an RC4 core, loops the
// captured ciphertext back for decryption and checks the recovered plaintext.
module rc4_stream_host #(
    parameter int KEY_LEN = 32,
    parameter int MSG_LEN = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       load_en,
    input  logic       load_sel,
    input  logic [5:0] load_addr,
    input  logic [7:0] load_data,
    output logic       key_valid,
    output logic [7:0] key_in,
    input  logic       plain_read,
    output logic       plain_in_valid,
    output logic [7:0] plain_in,
    input  logic       cipher_write,
    input  logic [7:0] cipher_out,
    input  logic       cipher_read,
    output logic       cipher_in_valid,
    output logic [7:0] cipher_in,
    input  logic       plain_write,
    input  logic [7:0] plain_out,
    output logic       busy,
    output logic       finished,
    output logic       pass,
    output logic       timeout,
    output logic [7:0] err_count
);
    typedef enum logic [2:0] {IDLE, KEY, WAIT_PR, PLAIN, WAIT_CR, CIPHER, FIN} state_t;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [6:0] ML = 7'(MSG_LEN);
    localparam logic [5:0] KL = 6'(KEY_LEN);

    state_t state;
    logic [7:0] key_buf [KEY_LEN];
    logic [7:0] plain_buf [MSG_LEN];
    logic [7:0] cipher_buf [MSG_LEN];
    logic [5:0] key_cnt;
    logic [6:0] tx_ptr, rx_ptr;
    logic [WW-1:0] wd;
    logic enc, dec, rd, tx_ok, wr, rx_ok, bad, done, act, wd_hit;

    // A read seen in a wait state is served at once, keeping the request-to-data latency at one cycle.
    always_comb begin
        enc = state == WAIT_PR || state == PLAIN;
        dec = state == WAIT_CR || state == CIPHER;
        rd = enc ? plain_read : dec && cipher_read;
        tx_ok = rd && tx_ptr < ML;
        wr = state == PLAIN ? cipher_write : state == CIPHER && plain_write;
        rx_ok = wr && rx_ptr < ML;
        bad = wr && (!rx_ok || (state == CIPHER && plain_out != plain_buf[rx_ptr[5:0]]));
        done = tx_ptr == ML && rx_ptr == ML;
        act = plain_read || cipher_read || cipher_write || plain_write;
        wd_hit = (enc || dec) && !act && wd == WW'(TIMEOUT - 1);
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && load_en && load_sel) plain_buf[load_addr] <= load_data;
        if (state == IDLE && load_en && !load_sel) key_buf[load_addr[4:0]] <= load_data;
        if (state == PLAIN && rx_ok) cipher_buf[rx_ptr[5:0]] <= cipher_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            key_valid <= 1'b0;
            key_in <= 8'h00;
            plain_in_valid <= 1'b0;
            plain_in <= 8'h00;
            cipher_in_valid <= 1'b0;
            cipher_in <= 8'h00;
            busy <= 1'b0;
            finished <= 1'b0;
            pass <= 1'b0;
            timeout <= 1'b0;
            err_count <= 8'h00;
            key_cnt <= '0;
            tx_ptr <= '0;
            rx_ptr <= '0;
            wd <= '0;
        end else begin
            plain_in_valid <= 1'b0;
            cipher_in_valid <= 1'b0;
            wd <= act ? '0 : wd + 1'b1;
            if (tx_ok) begin
                if (enc) begin
                    plain_in_valid <= 1'b1;
                    plain_in <= plain_buf[tx_ptr[5:0]];
                end else begin
                    cipher_in_valid <= 1'b1;
                    cipher_in <= cipher_buf[tx_ptr[5:0]];
                end
                tx_ptr <= tx_ptr + 7'd1;
            end
            if (rx_ok) rx_ptr <= rx_ptr + 7'd1;
            if (bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
            case (state)
                IDLE, FIN: begin
                    if (state == FIN) begin
                        finished <= 1'b1;
                        pass <= err_count == 8'h00 && !timeout;
                    end
                    if (start) begin
                        state <= KEY;
                        key_valid <= 1'b1;
                        key_in <= 8'h00;
                        key_cnt <= '0;
                        busy <= 1'b1;
                        finished <= 1'b0;
                        pass <= 1'b0;
                        timeout <= 1'b0;
                        err_count <= 8'h00;
                        tx_ptr <= '0;
                        rx_ptr <= '0;
                        wd <= '0;
                    end
                end
                KEY: begin
                    if (key_cnt == KL) begin
                        state <= WAIT_PR;
                        key_valid <= 1'b0;
                        key_in <= 8'h00;
                        wd <= '0;
                    end else begin
                        key_in <= key_buf[key_cnt[4:0]];
                        key_cnt <= key_cnt + 6'd1;
                    end
                end
                WAIT_PR: if (plain_read) begin
                    state <= PLAIN;
                    wd <= '0;
                end
                PLAIN: if (done) begin
                    state <= WAIT_CR;
                    tx_ptr <= '0;
                    rx_ptr <= '0;
                    wd <= '0;
                end
                WAIT_CR: if (cipher_read) begin
                    state <= CIPHER;
                    wd <= '0;
                end
                CIPHER: if (done) begin
                    state <= FIN;
                    busy <= 1'b0;
                    wd <= '0;
                end
                default: ;
            endcase
            if (wd_hit) begin
                state <= FIN;
                busy <= 1'b0;
                timeout <= 1'b1;
                wd <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rc4_stream_host.sv
// tb_rc4_stream_host: directed round trips against a simple XOR-keystream core model.
module tb_rc4_stream_host;
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, load_en = 1'b0, load_sel = 1'b0;
    logic [5:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic key_valid, plain_in_valid, cipher_in_valid, busy, finished, pass, timeout;
    logic [7:0] key_in, plain_in, cipher_in, err_count;
    logic plain_read = 1'b0, cipher_write = 1'b0, cipher_read = 1'b0, plain_write = 1'b0;
    logic [7:0] cipher_out = '0, plain_out = '0;

    int checks = 0, failures = 0;
    logic [7:0] kcap [32];
    logic [7:0] pcap [64];
    logic [7:0] ccap [64];
    logic [7:0] first_key;
    int key_cycles, np, nc, lat_err;
    logic tmo16, tmo17;
    bit hang;

    always #5 clk = ~clk;

    rc4_stream_host #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .key_valid(key_valid), .key_in(key_in),
        .plain_read(plain_read), .plain_in_valid(plain_in_valid), .plain_in(plain_in),
        .cipher_write(cipher_write), .cipher_out(cipher_out), .cipher_read(cipher_read),
        .cipher_in_valid(cipher_in_valid), .cipher_in(cipher_in), .plain_write(plain_write),
        .plain_out(plain_out), .busy(busy), .finished(finished), .pass(pass),
        .timeout(timeout), .err_count(err_count)
    );

    // Model keystream derived from the key bytes the core actually received.
    function automatic logic [7:0] ks(int i);
        return kcap[i % 32] ^ 8'h5A ^ 8'(i * 7);
    endfunction

    // Expected ciphertext from the loaded constants: key[j]=j, msg[i]=0x41+i.
    function automatic logic [7:0] exp_c(int i);
        return 8'(8'h41 + i) ^ 8'(i % 32) ^ 8'h5A ^ 8'(i * 7);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_bufs;
        for (int i = 0; i < 96; i++) begin
            load_en = 1'b1;
            load_sel = i >= 32;
            load_addr = 6'(i >= 32 ? i - 32 : i);
            load_data = 8'(i >= 32 ? 8'h41 + i - 32 : i);
            step;
        end
        load_en = 1'b0;
    endtask

    task automatic run_trip(input int corrupt, input int drop_at, input int extra, input bit no_cread);
        int req, drop_left, cyc, nw;
        bit pr_prev, dropped;
        key_cycles = 0; np = 0; nc = 0; lat_err = 0; hang = 0; first_key = 'x;
        for (int i = 0; i < 64; i++) begin pcap[i] = 'x; ccap[i] = 'x; end
        for (int i = 0; i < 32; i++) kcap[i] = 'x;
        start = 1'b1;
        step;
        start = 1'b0;
        cyc = 0;
        while (key_valid && cyc < 100) begin
            if (key_cycles == 0) first_key = key_in;
            else if (key_cycles <= 32) kcap[key_cycles-1] = key_in;
            key_cycles++;
            start = key_cycles == 5;
            step;
            cyc++;
        end
        start = 1'b0;
        req = 0; drop_left = 0; pr_prev = 0; dropped = 0; nw = 0; cyc = 0;
        while (nw < 64 + extra && cyc < 400) begin
            if (plain_in_valid !== pr_prev) lat_err++;
            cipher_write = 1'b0;
            if (plain_in_valid) begin
                if (np < 64) pcap[np] = plain_in;
                cipher_write = 1'b1;
                cipher_out = plain_in ^ ks(np);
                np++;
                nw++;
            end else if (np >= 64) begin
                cipher_write = 1'b1;
                cipher_out = 8'hEE;
                nw++;
            end
            if (req == drop_at && !dropped) begin drop_left = 3; dropped = 1; end
            plain_read = req < 64 && drop_left == 0;
            if (drop_left > 0) drop_left--;
            if (plain_read) req++;
            pr_prev = plain_read;
            step;
            cyc++;
        end
        if (cyc >= 400) hang = 1;
        cipher_write = 1'b0;
        plain_read = 1'b0;
        if (no_cread) begin
            for (int k = 1; k <= 17; k++) begin
                step;
                if (k == 16) tmo16 = timeout;
                if (k == 17) tmo17 = timeout;
            end
        end else begin
            step;
            req = 0; nw = 0; cyc = 0;
            while (nw < 64 && cyc < 400) begin
                plain_write = 1'b0;
                if (cipher_in_valid) begin
                    if (nc < 64) ccap[nc] = cipher_in;
                    plain_write = 1'b1;
                    plain_out = cipher_in ^ ks(nc) ^ (nc == corrupt ? 8'h01 : 8'h00);
                    nc++;
                    nw++;
                end
                cipher_read = req < 64;
                if (cipher_read) req++;
                step;
                cyc++;
            end
            if (cyc >= 400) hang = 1;
            plain_write = 1'b0;
            cipher_read = 1'b0;
        end
        cyc = 0;
        while (!finished && cyc < 40) begin step; cyc++; end
        if (!finished) hang = 1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) step;
        checks++; if ({key_valid, plain_in_valid, cipher_in_valid, busy, finished, pass, timeout} !== 7'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000000", {key_valid, plain_in_valid, cipher_in_valid, busy, finished, pass, timeout}); end
        checks++; if ({key_in, plain_in, cipher_in} !== 24'h0) begin failures++; $display("FAIL reset_data got=%h want=000000", {key_in, plain_in, cipher_in}); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL reset_err got=%h want=00", err_count); end
        rst = 1'b0;
        step;
    endtask

    task automatic test_reset_mid_key;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (9) step;
        checks++; if ({key_valid, busy, key_in} !== {2'b11, 8'h08}) begin failures++; $display("FAIL mid_key_state got=%b/%h want=11/08", {key_valid, busy}, key_in); end
        rst = 1'b1;
        step;
        checks++; if ({key_valid, key_in, plain_in_valid, plain_in, cipher_in_valid, cipher_in, busy, finished, pass, timeout, err_count} !== 39'd0) begin failures++; $display("FAIL mid_key_reset got kv=%b ki=%h busy=%b err=%h want all 0", key_valid, key_in, busy, err_count); end
        rst = 1'b0;
        step;
    endtask

    task automatic test_round_trip;
        int kb, pb, cb;
        run_trip(-1, -1, 0, 0);
        kb = 0; pb = 0; cb = 0;
        for (int i = 0; i < 32; i++) if (kcap[i] !== 8'(i)) kb++;
        for (int i = 0; i < 64; i++) begin
            if (pcap[i] !== 8'(8'h41 + i)) pb++;
            if (ccap[i] !== exp_c(i)) cb++;
        end
        checks++; if (hang !== 1'b0) begin failures++; $display("FAIL rt_hang got=%0d want=0", hang); end
        checks++; if (key_cycles !== 33) begin failures++; $display("FAIL rt_key_cycles got=%0d want=33", key_cycles); end
        checks++; if (first_key !== 8'h00) begin failures++; $display("FAIL rt_preamble got=%h want=00", first_key); end
        checks++; if (kb !== 0) begin failures++; $display("FAIL rt_key_bytes bad=%0d want=0", kb); end
        checks++; if (pb !== 0) begin failures++; $display("FAIL rt_plain_stream bad=%0d want=0", pb); end
        checks++; if (cb !== 0) begin failures++; $display("FAIL rt_cipher_loopback bad=%0d want=0", cb); end
        checks++; if ({finished, pass, busy, timeout} !== 4'b1100) begin failures++; $display("FAIL rt_status got=%b want=1100", {finished, pass, busy, timeout}); end
        checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL rt_err got=%h want=00", err_count); end
    endtask

    task automatic test_corrupt;
        run_trip(5, -1, 0, 0);
        checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL corrupt_err got=%h want=01", err_count); end
        checks++; if ({finished, pass} !== 2'b10) begin failures++; $display("FAIL corrupt_status got=%b want=10", {finished, pass}); end
    endtask

    task automatic test_drop;
        int pb;
        run_trip(-1, 20, 0, 0);
        pb = 0;
        for (int i = 0; i < 64; i++) if (pcap[i] !== 8'(8'h41 + i)) pb++;
        checks++; if (lat_err !== 0) begin failures++; $display("FAIL drop_latency bad=%0d want=0", lat_err); end
        checks++; if (pb !== 0 || np !== 64) begin failures++; $display("FAIL drop_stream bad=%0d n=%0d want=0/64", pb, np); end
        checks++; if ({finished, pass, err_count} !== {2'b11, 8'h00}) begin failures++; $display("FAIL drop_status got=%b err=%h want=11/00", {finished, pass}, err_count); end
    endtask

    task automatic test_overflow;
        int cb;
        run_trip(-1, -1, 1, 0);
        cb = 0;
        for (int i = 0; i < 64; i++) if (ccap[i] !== exp_c(i)) cb++;
        checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL ovf_err got=%h want=01", err_count); end
        checks++; if ({finished, pass} !== 2'b10) begin failures++; $display("FAIL ovf_status got=%b want=10", {finished, pass}); end
        checks++; if (cb !== 0) begin failures++; $display("FAIL ovf_cipher_kept bad=%0d last=%h want=0/%h", cb, ccap[63], exp_c(63)); end
    endtask

    task automatic test_timeout;
        run_trip(-1, -1, 0, 1);
        checks++; if (tmo16 !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b want=0", tmo16); end
        checks++; if (tmo17 !== 1'b1) begin failures++; $display("FAIL tmo_at_16 got=%b want=1", tmo17); end
        checks++; if ({finished, pass, busy, timeout} !== 4'b1001) begin failures++; $display("FAIL tmo_status got=%b want=1001", {finished, pass, busy, timeout}); end
    endtask

    initial begin
        test_reset;
        load_bufs;
        test_reset_mid_key;
        test_round_trip;
        test_corrupt;
        test_drop;
        test_overflow;
        test_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit checks=%0d", checks);
        $fatal(1, "time limit");
    end
endmodule
